// File: rtl/tff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tff_pkg                                                         |
// | Purpose  : Shared direction constants and modulo next-count helper.       |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package tff_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Modulo step in either direction; wraps at modulus rather than at a power of two.
  function automatic int unsigned next_count(input int unsigned q,
                                             input logic        up_dn,
                                             input int unsigned modulus);
    if (up_dn == CNT_DOWN)
      return (q == 0) ? modulus - 1 : q - 1;
    return (q == modulus - 1) ? 0 : q + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/t_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : t_cell                                                          |
// | Purpose  : Single T flip-flop with true/complement outputs.               |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module t_cell
  import tff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_q <= 1'b0;
    else if (t)
      r_q <= ~r_q;
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule
`default_nettype wire

// File: rtl/tff_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tff_mod_counter                                                 |
// | Purpose  : Modulo-N up/down counter with loadable value, built on T cells.|
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);

  generate
    if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (64'sd1 <<< WIDTH)) begin : g_bad_params
      $error("tff_mod_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_tc;
  logic             r_wrap;

  // Only the modulo-reduced next value is ever turned into toggles.
  always_comb begin
    w_next = w_q;
    if (load)
      w_next = (32'(din) >= 32'(MODULUS)) ? c_MAX : din;
    else if (en)
      w_next = WIDTH'(next_count(32'(w_q), up_dn, 32'(MODULUS)));
  end

  assign w_t = w_q ^ w_next;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .t    (w_t[i]),
        .q    (w_q[i]),
        .qbar (w_qbar[i])
      );
    end
  endgenerate

  assign w_tc = en & ~load &
                ((up_dn & (w_q == c_MAX)) | (~up_dn & (w_q == '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wrap <= 1'b0;
    else
      r_wrap <= w_tc;
  end

  assign q    = w_q;
  assign qbar = w_qbar;
  assign tc   = w_tc;
  assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_tff_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tff_mod_counter                                              |
// | Purpose  : Directed + random check of tff_mod_counter against a model.    |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tff_mod_counter;
  import tff_pkg::*;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;
  logic         wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: plain integer count and the wrap flag seen last edge.
  int m_q    = 0;
  int m_wrap = 0;

  always #5 clk = ~clk;

  tff_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .up_dn (up_dn),
    .load  (load),
    .din   (din),
    .q     (q),
    .qbar  (qbar),
    .tc    (tc),
    .wrap  (wrap)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_next(input int cur, input int e, input int u,
                                    input int l, input int d);
    if (l != 0) return (d >= M) ? M - 1 : d;
    if (e == 0) return cur;
    return (u != 0) ? (cur + 1) % M : (cur + M - 1) % M;
  endfunction

  function automatic int model_tc(input int cur, input int e, input int u, input int l);
    if (e == 0 || l != 0) return 0;
    return (u != 0) ? int'(cur == M - 1) : int'(cur == 0);
  endfunction

  // Drive one cycle's controls just after an edge, check tc, then outputs after the next edge.
  task automatic cyc(input string tag, input int e, input int u, input int l, input int d);
    int exp_tc;
    int nxt;
    en    = e[0];
    up_dn = u[0];
    load  = l[0];
    din   = W'(d);
    #1;
    exp_tc = model_tc(m_q, e, u, l);
    nxt    = model_next(m_q, e, u, l, d);
    chk({tag, ".tc"}, int'(tc), exp_tc);
    @(posedge clk);
    #1;
    m_q    = nxt;
    m_wrap = exp_tc;
    chk({tag, ".q"},    int'(q),    m_q);
    chk({tag, ".qbar"}, int'(qbar), (~m_q) & ((1 << W) - 1));
    chk({tag, ".wrap"}, int'(wrap), m_wrap);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".q"},    int'(q),    0);
    chk({tag, ".qbar"}, int'(qbar), (1 << W) - 1);
    chk({tag, ".wrap"}, int'(wrap), 0);
    m_q    = 0;
    m_wrap = 0;
  endtask

  initial begin
    // Power-on reset; tc must still follow its equation while rst is high.
    en = 1'b1; up_dn = CNT_DOWN; load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset("por");
    chk("por.tc_down", int'(tc), 1);
    up_dn = CNT_UP;
    #1 chk("por.tc_up", int'(tc), 0);
    @(posedge clk); @(posedge clk); #1;
    chk_reset("por_hold");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.q", int'(q), 1);
    m_q = 1;

    // Re-enter a clean state at 0 and count up through the wrap.
    cyc("ld0", 0, 1, 1, 0);
    for (int i = 0; i < 12; i++) cyc("up", 1, 1, 0, 0);

    // Count down through zero.
    cyc("ld2", 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) cyc("dn", 1, 0, 0, 0);

    // Out-of-range load saturates; load beats enable at a terminal value.
    cyc("ld13", 0, 1, 1, 13);
    cyc("ld_en", 1, 1, 1, 5);
    cyc("ld9_dn", 1, 0, 1, 9);
    cyc("ld0_dn", 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("hold", 0, 1, 0, 0);

    // Mid-count asynchronous reset, no clock edge needed.
    cyc("ld7", 0, 1, 1, 7);
    en = 1'b1; up_dn = CNT_UP; load = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset("arst");
    @(negedge clk) rst = 1'b0;
    cyc("resume", 1, 1, 0, 0);

    // A pending wrap must be cleared by reset.
    cyc("ld9", 0, 1, 1, 9);
    cyc("wrap_set", 1, 1, 0, 0);
    #2 rst = 1'b1;
    #1 chk_reset("arst_wrap");
    @(negedge clk) rst = 1'b0;
    cyc("resume2", 0, 1, 0, 0);

    // Direction flips every cycle; also cross-check the shared helper.
    cyc("ld4", 0, 1, 1, 4);
    for (int i = 0; i < 4; i++) begin
      chk("flip.nc", int'(next_count(32'(m_q), ((i % 2) == 0), 32'(M))),
          model_next(m_q, 1, int'((i % 2) == 0), 0, 0));
      cyc("flip", 1, int'((i % 2) == 0), 0, 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 7) == 0), int'($urandom_range(0, (1 << W) - 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
